bcd_mux_display: RTL and testbench

Parametrised, time-multiplexed N-digit 7-segment driver, the successor to the single-digit BCD-to-7-segment decoder. It holds a double-buffered BCD/hex word and scans one digit per refresh slot onto a shared segment bus with per-digit enables. Added features: a dead-time gap against ghosting, leading-zero suppression, decimal points, and tear-free frame-aligned updates. It sits between the lab datapath (counters, keypad logic) and the board's display pins.

---
 rtl/bcd_mux_display.sv | 170 +++++++++++++++++
 tb/tb_bcd_mux_display.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_mux_display.sv
`timescale 1ns/1ps
// Time-multiplexed N-digit 7-segment driver with a double-buffered, frame-aligned display word.
// Latency: all pins registered, one cycle behind the prescaler/index state; FRAME likewise.
// Backpressure: none; LOAD is always accepted, and the last LOAD before a frame wrap wins.
module bcd_mux_display #(
   parameter int DIGITS         = 4,
   parameter int CLK_DIV        = 50000,
   parameter bit HEX_MODE       = 1'b0,
   parameter bit LZ_SUPPRESS    = 1'b1,
   parameter bit SEG_ACTIVE_LOW = 1'b0,
   parameter bit AN_ACTIVE_LOW  = 1'b1
) (
   input  logic                  CLK,
   input  logic                  RST_N,
   input  logic                  LOAD,
   input  logic [4*DIGITS-1:0]   DATA,
   input  logic [DIGITS-1:0]     DP,
   input  logic                  BLANK,
   output logic [6:0]            SEG_7,
   output logic                  SEG_DP,
   output logic [DIGITS-1:0]     ANODE,
   output logic                  FRAME
);

   localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   // XOR masks turning active-high internal values into pin polarity
   localparam logic [DIGITS-1:0] AN_OFF  = AN_ACTIVE_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};
   localparam logic [6:0]        SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
   localparam logic              DP_OFF  = SEG_ACTIVE_LOW ? 1'b1 : 1'b0;

   logic [PW-1:0]         presc;
   logic [IW-1:0]         idx;
   logic                  tc;
   logic                  last_digit;
   logic                  wrap;

   logic [4*DIGITS-1:0]   shadow_data;
   logic [DIGITS-1:0]     shadow_dp;
   logic [4*DIGITS-1:0]   active_data;
   logic [DIGITS-1:0]     active_dp;
   logic                  pending;

   logic [DIGITS-1:0]     lit_mask;
   logic                  upper_zero;
   logic [DIGITS-1:0]     onehot;
   logic [3:0]            cur_code;
   logic                  cur_dp;
   logic [DIGITS-1:0]     an_nxt;
   logic [6:0]            seg_nxt;
   logic                  dp_nxt;

   function automatic logic [6:0] seg_decode(input logic [3:0] code);
      logic [6:0] seg;
      seg = 7'h00;
      case (code)
         4'd0:  seg = 7'h7E;
         4'd1:  seg = 7'h30;
         4'd2:  seg = 7'h6D;
         4'd3:  seg = 7'h79;
         4'd4:  seg = 7'h33;
         4'd5:  seg = 7'h5B;
         4'd6:  seg = 7'h5F;
         4'd7:  seg = 7'h70;
         4'd8:  seg = 7'h7F;
         4'd9:  seg = 7'h7B;
         4'd10: seg = HEX_MODE ? 7'h77 : 7'h00;
         4'd11: seg = HEX_MODE ? 7'h1F : 7'h00;
         4'd12: seg = HEX_MODE ? 7'h4E : 7'h00;
         4'd13: seg = HEX_MODE ? 7'h3D : 7'h00;
         4'd14: seg = HEX_MODE ? 7'h4F : 7'h00;
         4'd15: seg = HEX_MODE ? 7'h47 : 7'h00;
         default: seg = 7'h00;
      endcase
      return seg;
   endfunction

   assign tc         = (presc == PW'(CLK_DIV - 1));
   assign last_digit = (idx == IW'(DIGITS - 1));
   assign wrap       = tc && last_digit;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         presc <= '0;
         idx   <= '0;
      end else if (tc) begin
         presc <= '0;
         idx   <= last_digit ? '0 : idx + IW'(1);
      end else begin
         presc <= presc + PW'(1);
      end
   end

   // Active only changes on the wrap edge so a frame is never torn
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         shadow_data <= '0;
         shadow_dp   <= '0;
         active_data <= '0;
         active_dp   <= '0;
         pending     <= 1'b0;
      end else begin
         if (LOAD) begin
            shadow_data <= DATA;
            shadow_dp   <= DP;
         end
         if (wrap) begin
            pending <= 1'b0;
            if (LOAD) begin
               active_data <= DATA;
               active_dp   <= DP;
            end else if (pending) begin
               active_data <= shadow_data;
               active_dp   <= shadow_dp;
            end
         end else if (LOAD) begin
            pending <= 1'b1;
         end
      end
   end

   // Walk from the top digit down; a digit stays lit once anything above or at it is non-zero
   always_comb begin
      lit_mask   = '0;
      upper_zero = 1'b1;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         upper_zero  = upper_zero && (active_data[4*i +: 4] == 4'd0) && !active_dp[i];
         lit_mask[i] = (i == 0) || !(LZ_SUPPRESS && upper_zero);
      end
   end

   always_comb begin
      onehot = '0;
      for (int i = 0; i < DIGITS; i++) begin
         onehot[i] = (idx == IW'(i));
      end
   end

   assign cur_code = active_data[4*int'(idx) +: 4];
   assign cur_dp   = active_dp[idx];

   // Slot position 0 is the dead-time gap: anodes off, segments already on the new digit
   always_comb begin
      an_nxt  = '0;
      seg_nxt = seg_decode(cur_code);
      dp_nxt  = 1'b0;
      if (presc != '0) begin
         dp_nxt = cur_dp;
         if (!BLANK) begin
            an_nxt = onehot & lit_mask;
         end
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         ANODE  <= AN_OFF;
         SEG_7  <= SEG_OFF;
         SEG_DP <= DP_OFF;
         FRAME  <= 1'b0;
      end else begin
         ANODE  <= AN_OFF ^ an_nxt;
         SEG_7  <= SEG_OFF ^ seg_nxt;
         SEG_DP <= DP_OFF ^ dp_nxt;
         FRAME  <= wrap;
      end
   end

endmodule

// File: tb/tb_bcd_mux_display.sv
`timescale 1ns/1ps
// Directed bench for bcd_mux_display: 4 digits, 4-cycle slots, BCD and hex decoder instances.
module tb_bcd_mux_display;

   logic        CLK = 1'b0;
   logic        RST_N;
   logic        LOAD;
   logic [15:0] DATA;
   logic [3:0]  DP;
   logic        BLANK;

   logic [6:0]  seg_h0, seg_h1;
   logic        dp_h0, dp_h1;
   logic [3:0]  an_h0, an_h1;
   logic        fr_h0, fr_h1;

   int checks = 0;
   int errors = 0;

   always #5 CLK = ~CLK;

   bcd_mux_display #(.DIGITS(4), .CLK_DIV(4), .HEX_MODE(1'b0)) dut_bcd (
      .CLK(CLK), .RST_N(RST_N), .LOAD(LOAD), .DATA(DATA), .DP(DP), .BLANK(BLANK),
      .SEG_7(seg_h0), .SEG_DP(dp_h0), .ANODE(an_h0), .FRAME(fr_h0)
   );

   bcd_mux_display #(.DIGITS(4), .CLK_DIV(4), .HEX_MODE(1'b1)) dut_hex (
      .CLK(CLK), .RST_N(RST_N), .LOAD(LOAD), .DATA(DATA), .DP(DP), .BLANK(BLANK),
      .SEG_7(seg_h1), .SEG_DP(dp_h1), .ANODE(an_h1), .FRAME(fr_h1)
   );

   function automatic logic [6:0] exp_seg(input bit hex, input logic [3:0] c);
      case (c)
         4'd0:  return 7'h7E;
         4'd1:  return 7'h30;
         4'd2:  return 7'h6D;
         4'd3:  return 7'h79;
         4'd4:  return 7'h33;
         4'd5:  return 7'h5B;
         4'd6:  return 7'h5F;
         4'd7:  return 7'h70;
         4'd8:  return 7'h7F;
         4'd9:  return 7'h7B;
         4'd10: return hex ? 7'h77 : 7'h00;
         4'd11: return hex ? 7'h1F : 7'h00;
         4'd12: return hex ? 7'h4E : 7'h00;
         4'd13: return hex ? 7'h3D : 7'h00;
         4'd14: return hex ? 7'h4F : 7'h00;
         default: return hex ? 7'h47 : 7'h00;
      endcase
   endfunction

   // Called at a negedge; LOAD is high for exactly the next rising edge
   task automatic do_load(input logic [15:0] d, input logic [3:0] p);
      LOAD = 1'b1;
      DATA = d;
      DP   = p;
      @(negedge CLK);
      LOAD = 1'b0;
   endtask

   // Returns once FRAME is seen high at a negedge, or after a bounded number of cycles
   task automatic wait_frame(input bit sel, output bit ok);
      ok = 1'b0;
      for (int n = 0; n < 40; n++) begin
         if ((sel ? fr_h1 : fr_h0) === 1'b1) begin
            ok = 1'b1;
            break;
         end
         @(negedge CLK);
      end
   endtask

   // Samples the 16 cycles following a FRAME sample, counting cycles that differ from the model
   task automatic observe_frame(input bit sel, input logic [15:0] data, input logic [3:0] dp,
                                input int load_k, input logic [15:0] ld_d, input logic [3:0] ld_p,
                                input int bl_from, input int bl_to,
                                output int bad, output string info);
      logic [3:0]  an, an_e, nib;
      logic [6:0]  seg, seg_e;
      logic        dpo, dp_e, fr, fr_e;
      logic [15:0] up;
      logic [3:0]  upd;
      bit          supp, blanked, miss;
      int          s, sub;
      bad  = 0;
      info = "";
      for (int k = 0; k < 16; k++) begin
         @(negedge CLK);
         an  = sel ? an_h1  : an_h0;
         seg = sel ? seg_h1 : seg_h0;
         dpo = sel ? dp_h1  : dp_h0;
         fr  = sel ? fr_h1  : fr_h0;
         s   = k / 4;
         sub = k % 4;
         nib = data[4*s +: 4];
         up  = data >> (4*s);
         upd = dp >> s;
         supp    = (s > 0) && (up == 16'h0) && (upd == 4'h0);
         blanked = (k - 1 >= bl_from) && (k - 1 <= bl_to);
         an_e  = (sub == 0 || supp || blanked) ? 4'hF : ~(4'b0001 << s);
         seg_e = exp_seg(sel, nib);
         dp_e  = (sub == 0) ? 1'b0 : dp[s];
         fr_e  = (k == 15);
         miss = (an !== an_e) || (fr !== fr_e);
         if (!blanked && !(sub != 0 && supp))
            miss = miss || (seg !== seg_e);
         if (!blanked)
            miss = miss || (dpo !== dp_e);
         if (miss) begin
            bad++;
            if (info == "")
               info = $sformatf("cycle %0d anode %b/%b seg %h/%h dp %b/%b frame %b/%b (got/want)",
                                k, an, an_e, seg, seg_e, dpo, dp_e, fr, fr_e);
         end
         LOAD  = (k == load_k);
         if (k == load_k) begin
            DATA = ld_d;
            DP   = ld_p;
         end
         BLANK = (k >= bl_from) && (k <= bl_to);
      end
      LOAD  = 1'b0;
      BLANK = 1'b0;
   endtask

   task automatic test_reset;
      RST_N = 1'b0;
      LOAD  = 1'b0;
      BLANK = 1'b0;
      DATA  = 16'h0;
      DP    = 4'h0;
      #22;
      checks++;
      if (an_h0 !== 4'hF) begin errors++; $display("FAIL reset_anode got %b want 1111", an_h0); end
      checks++;
      if (seg_h0 !== 7'h00) begin errors++; $display("FAIL reset_seg got %h want 00", seg_h0); end
      checks++;
      if (dp_h0 !== 1'b0) begin errors++; $display("FAIL reset_dp got %b want 0", dp_h0); end
      checks++;
      if (fr_h0 !== 1'b0) begin errors++; $display("FAIL reset_frame got %b want 0", fr_h0); end
      @(negedge CLK);
      RST_N = 1'b1;
   endtask

   task automatic test_scan;
      bit ok; int bad; string info;
      do_load(16'h1234, 4'b0000);
      wait_frame(0, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL scan_wait_frame got timeout want FRAME"); end
      for (int f = 0; f < 2; f++) begin
         observe_frame(0, 16'h1234, 4'b0000, -1, 16'h0, 4'h0, -1, -2, bad, info);
         checks++;
         if (bad !== 0) begin errors++; $display("FAIL scan_1234_f%0d got %0d bad cycles want 0: %s", f, bad, info); end
      end
   endtask

   task automatic test_lz;
      bit ok; int bad; string info;
      logic [15:0] dv [3] = '{16'h0007, 16'h0000, 16'h0000};
      logic [3:0]  pv [3] = '{4'b0000, 4'b0000, 4'b0100};
      for (int t = 0; t < 3; t++) begin
         do_load(dv[t], pv[t]);
         wait_frame(0, ok);
         checks++;
         if (!ok) begin errors++; $display("FAIL lz_wait_frame_%0d got timeout want FRAME", t); end
         observe_frame(0, dv[t], pv[t], -1, 16'h0, 4'h0, -1, -2, bad, info);
         checks++;
         if (bad !== 0) begin errors++; $display("FAIL lz_case_%0d got %0d bad cycles want 0: %s", t, bad, info); end
      end
   endtask

   task automatic test_back_to_back;
      bit ok; int bad; string info;
      do_load(16'h1111, 4'b0000);
      wait_frame(0, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL b2b_wait_frame got timeout want FRAME"); end
      observe_frame(0, 16'h1111, 4'b0000, 5, 16'h2222, 4'b0000, -1, -2, bad, info);
      checks++;
      if (bad !== 0) begin errors++; $display("FAIL b2b_old_frame got %0d bad cycles want 0: %s", bad, info); end
      observe_frame(0, 16'h2222, 4'b0000, -1, 16'h0, 4'h0, -1, -2, bad, info);
      checks++;
      if (bad !== 0) begin errors++; $display("FAIL b2b_new_frame got %0d bad cycles want 0: %s", bad, info); end
   endtask

   task automatic test_load_on_wrap;
      int bad; string info;
      observe_frame(0, 16'h2222, 4'b0000, 14, 16'h9999, 4'b0000, -1, -2, bad, info);
      checks++;
      if (bad !== 0) begin errors++; $display("FAIL wrap_old_frame got %0d bad cycles want 0: %s", bad, info); end
      observe_frame(0, 16'h9999, 4'b0000, -1, 16'h0, 4'h0, -1, -2, bad, info);
      checks++;
      if (bad !== 0) begin errors++; $display("FAIL wrap_new_frame got %0d bad cycles want 0: %s", bad, info); end
   endtask

   task automatic test_hex;
      bit ok; int bad; string info;
      do_load(16'hABCD, 4'b0000);
      wait_frame(0, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL hex_wait_frame got timeout want FRAME"); end
      observe_frame(0, 16'hABCD, 4'b0000, -1, 16'h0, 4'h0, -1, -2, bad, info);
      checks++;
      if (bad !== 0) begin errors++; $display("FAIL hex_mode0 got %0d bad cycles want 0: %s", bad, info); end
      observe_frame(1, 16'hABCD, 4'b0000, -1, 16'h0, 4'h0, -1, -2, bad, info);
      checks++;
      if (bad !== 0) begin errors++; $display("FAIL hex_mode1 got %0d bad cycles want 0: %s", bad, info); end
   endtask

   task automatic test_reset_mid;
      int bad; string info;
      @(negedge CLK);
      @(negedge CLK);
      #2 RST_N = 1'b0;
      #1;
      checks++;
      if (an_h1 !== 4'hF) begin errors++; $display("FAIL midreset_anode got %b want 1111", an_h1); end
      checks++;
      if (seg_h1 !== 7'h00) begin errors++; $display("FAIL midreset_seg got %h want 00", seg_h1); end
      checks++;
      if (dp_h1 !== 1'b0) begin errors++; $display("FAIL midreset_dp got %b want 0", dp_h1); end
      checks++;
      if (fr_h1 !== 1'b0) begin errors++; $display("FAIL midreset_frame got %b want 0", fr_h1); end
      @(negedge CLK);
      @(negedge CLK);
      RST_N = 1'b1;
      observe_frame(1, 16'h0000, 4'b0000, -1, 16'h0, 4'h0, -1, -2, bad, info);
      checks++;
      if (bad !== 0) begin errors++; $display("FAIL midreset_restart got %0d bad cycles want 0: %s", bad, info); end
   endtask

   task automatic test_blank;
      int bad; string info;
      observe_frame(0, 16'h0000, 4'b0000, -1, 16'h0, 4'h0, 2, 11, bad, info);
      checks++;
      if (bad !== 0) begin errors++; $display("FAIL blank_frame got %0d bad cycles want 0: %s", bad, info); end
      observe_frame(0, 16'h0000, 4'b0000, -1, 16'h0, 4'h0, -1, -2, bad, info);
      checks++;
      if (bad !== 0) begin errors++; $display("FAIL blank_release got %0d bad cycles want 0: %s", bad, info); end
   endtask

   initial begin
      test_reset;
      test_scan;
      test_lz;
      test_back_to_back;
      test_load_on_wrap;
      test_hex;
      test_reset_mid;
      test_blank;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
